// File: rtl/mult_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states, Booth op codes, widths.
// Purely declarative; no logic or timing of its own.
package mult_pkg;

  localparam int WIDTH = 32;
  localparam int ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

  // Radix-2 Booth recoding of {q0, q-1}
  function automatic booth_op_t booth_op(input logic [1:0] bits);
    case (bits)
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step_decode.sv
// Maps the two low product bits and the multiplicand to the shared adder's B operand and carry-in.
// Combinational, zero latency.
module booth_step_decode #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       p_lo,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin
);

  import mult_pkg::*;

  booth_op_t op;

  assign op = booth_op(p_lo);

  // Subtraction is ~M plus carry-in, so the adder never needs a negator
  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    case (op)
      OP_ADD: add_b = m;
      OP_SUB: begin
        add_b   = ~m;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cla_adder.sv
// 32-bit carry-lookahead adder (4-bit groups) with signed-overflow flag.
// Purely combinational; no flow control.
module cla_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;

  assign g = a & b;
  assign p = a ^ b;

  // Group carries skip across each nibble; bit carries resolve inside it
  always_comb begin
    c    = '0;
    gg   = '0;
    gp   = '0;
    c[0] = cin;
    for (int j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
      for (int i = 0; i < 3; i++) begin
        c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
      end
      c[4*j+4] = gg[j] | (gp[j] & c[4*j]);
    end
  end

  assign sum      = p ^ c[WIDTH-1:0];
  assign overflow = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/booth_mult_seq.sv
// Signed 32x32 radix-2 Booth multiplier driving an external shared adder, one add per cycle.
// Ready strobe 33 cycles after start; start is ignored while busy.
module booth_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_overflow,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  import mult_pkg::*;

  state_t             state;
  state_t             state_nx;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH:0]   p_q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   dec_b;
  logic               dec_cin;
  logic               run;
  logic               start;
  logic               guard;

  assign run   = (state == RUN);
  assign start = ctrl_MULT && ((state == IDLE) || (state == DONE));
  assign busy  = run;

  booth_step_decode #(.WIDTH(WIDTH)) u_decode (
    .p_lo    (p_q[1:0]),
    .m       (m_q),
    .add_b   (dec_b),
    .add_cin (dec_cin)
  );

  // Adder inputs are forced to zero outside RUN so the shared adder sees no stray activity
  assign add_a   = run ? p_q[2*WIDTH:WIDTH+1] : '0;
  assign add_b   = run ? dec_b : '0;
  assign add_cin = run & dec_cin;

  // The 33rd sum bit: the 32-bit sign is wrong exactly when the adder overflowed
  assign guard = add_overflow ? ~add_sum[WIDTH-1] : add_sum[WIDTH-1];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ctrl_MULT) state_nx = RUN;
      RUN:     if (cnt == CNT_W'(ITERS - 1)) state_nx = DONE;
      DONE:    state_nx = ctrl_MULT ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      m_q            <= '0;
      p_q            <= '0;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      state          <= state_nx;
      data_resultRDY <= (state == DONE);
      if (state == DONE) begin
        data_result    <= p_q[WIDTH:1];
        data_exception <= (p_q[2*WIDTH:WIDTH+1] != {WIDTH{p_q[WIDTH]}});
      end
      if (start) begin
        m_q <= data_operandA;
        p_q <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
        cnt <= '0;
      end else if (run) begin
        p_q <= {guard, add_sum, p_q[WIDTH:1]};
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
